// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard unit for a 5-stage F/D/E/M/W pipeline.
// It produces the EX-stage forwarding selects, load-use and branch-flush
// controls, and a memory wait-state FSM that freezes the pipeline while the
// data memory has not acknowledged a MEM-stage access.
// Optional feature macro: PIPE_PERF_CNT_EN adds the saturating StallCnt and
// FlushCnt performance counters and their ports.
// All control outputs are combinational. Only the FSM state, the wait counter,
// MemErr and the perf counters are flops.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             MemReadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_WAIT = 2'd1;
    localparam logic [1:0] M_ERR  = 2'd2;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    logic [1:0] state;
    logic [7:0] wcnt;
    logic       mem_err;
    logic       lw_stall;
    logic       mem_stall;

    // Select for one EX operand: M beats W, and x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)
            return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard conditions: load-use against D sources, and memory not ready.
    always_comb begin
        lw_stall  = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        mem_stall = (state == M_IDLE && MemReqM && !MemReadyM) ||
                    (state == M_WAIT && !MemReadyM) ||
                    (state == M_ERR);
    end

    // Memory wait FSM: wcnt counts stalled cycles of the current access;
    // M_ERR is terminal until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= M_IDLE;
            wcnt    <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        state <= M_WAIT;
                        wcnt  <= 8'd1;
                    end
                end
                M_WAIT: begin
                    if (MemReadyM) begin
                        state <= M_IDLE;
                        wcnt  <= 8'd0;
                    end else if (wcnt == TMO) begin
                        state   <= M_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                M_ERR: begin
                end
                default: begin
                    state <= M_IDLE;
                    wcnt  <= 8'd0;
                end
            endcase
        end
    end

    // Stage controls. Reset purges the pipeline with flushes and no stalls;
    // otherwise a memory stall freezes everything and defers any flush.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            StallF    = mem_stall | lw_stall;
            StallD    = mem_stall | lw_stall;
            StallE    = mem_stall;
            StallM    = mem_stall;
            // Bubble in WB so the frozen M instruction is written only once.
            FlushW    = mem_stall;
            FlushD    = PCSrcE & ~mem_stall;
            FlushE    = (lw_stall | PCSrcE) & ~mem_stall;
        end
    end

    assign MemErr = mem_err;

`ifdef PIPE_PERF_CNT_EN
    // Saturating counters of stalled-fetch cycles and E-stage flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && StallCnt != '1)
                StallCnt <= StallCnt + 1'b1;
            if (FlushE && FlushCnt != '1)
                FlushCnt <= FlushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model that tracks the length of the
// current stall streak instead of the FSM state.
module tb_pipeline_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       memreade, regwritem, regwritew, pcsrce, memreqm, memreadym;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int     streak = 0;
    bit     err    = 0;
    longint m_scnt = 0;
    longint m_fcnt = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
        .RdE(rde), .RdM(rdm), .RdW(rdw),
        .MemReadE(memreade), .RegWriteM(regwritem), .RegWriteW(regwritew),
        .PCSrcE(pcsrce), .MemReqM(memreqm), .MemReadyM(memreadym),
        .ForwardAE(fwd_a), .ForwardBE(fwd_b),
        .StallF(stall_f), .StallD(stall_d), .StallE(stall_e), .StallM(stall_m),
        .FlushD(flush_d), .FlushE(flush_e), .FlushW(flush_w),
        .MemErr(mem_err)
`ifdef PIPE_PERF_CNT_EN
        , .StallCnt(stall_cnt), .FlushCnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwritem && rdm != 0 && rdm == rs) return 2'b10;
        if (regwritew && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {memreade, regwritem, regwritew, pcsrce, memreqm} = '0;
        memreadym = 1'b1;
    endtask

    // One cycle: inputs already applied after a negedge. Check the model's
    // expectation, then advance the model across the posedge.
    task automatic tick();
        logic [1:0] ea, eb;
        logic [3:0] es;
        logic [2:0] ef;
        bit lw, ms;
        longint cmax;
        cmax = (64'd1 << CNT_W) - 1;
        #1;
        if (!rst_n) begin
            streak = 0; err = 0; m_scnt = 0; m_fcnt = 0;
        end
        lw = memreade && rde != 0 && (rde == rs1d || rde == rs2d);
        ms = err || (!memreadym && (memreqm || streak > 0));
        if (!rst_n) begin
            ea = 2'b00; eb = 2'b00; es = 4'b0000; ef = 3'b111;
        end else begin
            ea = ref_fwd(rs1e);
            eb = ref_fwd(rs2e);
            es = {ms | lw, ms | lw, ms, ms};
            ef = {pcsrce & !ms, (lw | pcsrce) & !ms, ms};
        end
        chk("fwd_a", 64'(fwd_a), 64'(ea));
        chk("fwd_b", 64'(fwd_b), 64'(eb));
        chk("stall_fdem", 64'({stall_f, stall_d, stall_e, stall_m}), 64'(es));
        chk("flush_dew", 64'({flush_d, flush_e, flush_w}), 64'(ef));
        chk("mem_err", 64'(mem_err), 64'(err));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
`endif
        @(posedge clk);
        if (rst_n) begin
            if (!err) begin
                if (ms) begin
                    streak++;
                    if (streak == TMO + 1) err = 1;
                end else begin
                    streak = 0;
                end
            end
            if (es[3] && m_scnt != cmax) m_scnt++;
            if (ef[1] && m_fcnt != cmax) m_fcnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("rst_flush", 64'({flush_d, flush_e, flush_w}), 64'(3'b111));
        chk("rst_stall", 64'({stall_f, stall_d, stall_e, stall_m}), 64'(4'b0000));
        tick();
        rst_n = 1'b1;
        tick();

        // T1 forwarding
        rdm = 5'd5; regwritem = 1'b1; rs1e = 5'd5;
        #1 chk("t1_fwd_m", 64'(fwd_a), 64'(2'b10));
        tick();
        rdm = 5'd0;
        #1 chk("t1_fwd_x0", 64'(fwd_a), 64'(2'b00));
        tick();
        rdm = 5'd7; rdw = 5'd7; regwritew = 1'b1; rs2e = 5'd7;
        #1 chk("t1_fwd_prio", 64'(fwd_b), 64'(2'b10));
        tick();
        idle_inputs();

        // T2 load-use: one stall cycle, then E holds a bubble
        memreade = 1'b1; rde = 5'd3; rs2d = 5'd3;
        #1 chk("t2_lu", 64'({stall_f, stall_d, flush_e, flush_d}), 64'(4'b1110));
        tick();
        memreade = 1'b0; rde = 5'd0;
        #1 chk("t2_lu_after", 64'({stall_f, stall_d, flush_e}), 64'(3'b000));
        tick();
        idle_inputs();

        // T3 branch flush
        pcsrce = 1'b1;
        #1 chk("t3_br", 64'({flush_d, flush_e, stall_f, stall_e}), 64'(4'b1100));
        tick();
        idle_inputs();

        // T4 memory wait with a pending taken branch
        pcsrce = 1'b1; memreqm = 1'b1; memreadym = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_wait", 64'({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d}),
                   64'(6'b111110));
            tick();
        end
        memreadym = 1'b1;
        #1 chk("t4_ack", 64'({stall_f, stall_m, flush_w, flush_d, flush_e}), 64'(5'b00011));
        tick();
        idle_inputs();

        // T5 timeout
        memreqm = 1'b1; memreadym = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_pre", 64'({stall_f, mem_err}), 64'(2'b10));
            tick();
        end
        memreqm = 1'b0; memreadym = 1'b1;
        #1 chk("t5_err", 64'({stall_f, stall_m, mem_err}), 64'(3'b111));
        tick();
        #1 chk("t5_sticky", 64'({stall_e, mem_err}), 64'(2'b11));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_inputs();

        // T6 reset mid-wait
        memreqm = 1'b1; memreadym = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1 chk("t6_rst", 64'({stall_f, stall_e, flush_d, flush_e, flush_w}), 64'(5'b00111));
`ifdef PIPE_PERF_CNT_EN
        chk("t6_cnt", 64'({stall_cnt, flush_cnt}), 64'(0));
`endif
        tick();
        rst_n = 1'b1; memreqm = 1'b0; memreadym = 1'b1;
        #1 chk("t6_idle", 64'({stall_f, mem_err}), 64'(2'b00));
        tick();

        // Randomized traffic with a short reset pulse every 60 cycles
        for (int c = 0; c < 1500; c++) begin
            rst_n     = (c % 60 != 59);
            rs1d      = 5'($urandom_range(0, 3));
            rs2d      = 5'($urandom_range(0, 3));
            rs1e      = 5'($urandom_range(0, 3));
            rs2e      = 5'($urandom_range(0, 3));
            rde       = 5'($urandom_range(0, 3));
            rdm       = 5'($urandom_range(0, 3));
            rdw       = 5'($urandom_range(0, 3));
            memreade  = 1'($urandom_range(0, 1));
            regwritem = 1'($urandom_range(0, 1));
            regwritew = 1'($urandom_range(0, 1));
            pcsrce    = ($urandom_range(0, 3) == 0);
            memreqm   = 1'($urandom_range(0, 1));
            memreadym = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
